// File: rtl/aes_pkg.sv
// Shared definitions for the iterative AES cipher: key-size encodings,
// round-count lookup and the round controller's FSM state encoding.
package aes_pkg;

  localparam logic [1:0] KL_128 = 2'b00;
  localparam logic [1:0] KL_192 = 2'b01;
  localparam logic [1:0] KL_256 = 2'b10;
  localparam logic [1:0] KL_BAD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_ROUND = 3'd2,
    ST_FINAL = 3'd3,
    ST_HOLD  = 3'd4
  } ctrl_state_t;

  // Number of full rounds Nr for a key size; the illegal code maps to 10
  // but is never latched because the controller rejects it.
  function automatic logic [3:0] nr_of(input logic [1:0] key_len);
    case (key_len)
      KL_192:  nr_of = 4'd12;
      KL_256:  nr_of = 4'd14;
      default: nr_of = 4'd10;
    endcase
  endfunction

endpackage

// File: rtl/aes_round_ctrl.sv
// Round sequencer for the iterative AES datapath: one block per start,
// drives round-key index, mux selects and state-register enable.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int RW  = 4,
  parameter int KLW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [KLW-1:0] key_len,
  output logic          in_ready,
  output logic [RW-1:0] rk_idx,
  output logic          sel_init,
  output logic          sel_final,
  output logic          sel_bypass,
  output logic          state_we,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          err
);

  ctrl_state_t   state;
  logic [RW-1:0] nr_q;
  logic [RW-1:0] last_round;

  assign last_round = nr_q - RW'(1);

  // Every output is a register updated together with the state, so no
  // input reaches an output combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      nr_q       <= RW'(10);
      rk_idx     <= '0;
      in_ready   <= 1'b1;
      sel_init   <= 1'b0;
      sel_final  <= 1'b0;
      sel_bypass <= 1'b0;
      state_we   <= 1'b0;
      out_valid  <= 1'b0;
      err        <= 1'b0;
    end else begin
      err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (key_len == KLW'(KL_BAD)) begin
              err <= 1'b1;
            end else begin
              nr_q       <= RW'(nr_of(key_len));
              state      <= ST_INIT;
              in_ready   <= 1'b0;
              rk_idx     <= '0;
              sel_init   <= 1'b1;
              sel_bypass <= 1'b1;
              state_we   <= 1'b1;
            end
          end
        end
        ST_INIT: begin
          state      <= ST_ROUND;
          rk_idx     <= RW'(1);
          sel_init   <= 1'b0;
          sel_bypass <= 1'b0;
        end
        ST_ROUND: begin
          rk_idx <= rk_idx + RW'(1);
          if (rk_idx == last_round) begin
            state     <= ST_FINAL;
            sel_final <= 1'b1;
          end
        end
        ST_FINAL: begin
          state     <= ST_HOLD;
          sel_final <= 1'b0;
          state_we  <= 1'b0;
          out_valid <= 1'b1;
        end
        ST_HOLD: begin
          // start is ignored here even on the release cycle; in_ready only
          // rises once IDLE is reached.
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            rk_idx    <= '0;
          end
        end
        default: begin
          state      <= ST_IDLE;
          rk_idx     <= '0;
          in_ready   <= 1'b1;
          sel_init   <= 1'b0;
          sel_final  <= 1'b0;
          sel_bypass <= 1'b0;
          state_we   <= 1'b0;
          out_valid  <= 1'b0;
        end
      endcase
    end
  end

endmodule
